// File: rtl/ser_pkg.sv
// Shared types for the bit serializer.
//   ser_state_t : FSM state encoding (the spare code 2'b11 is recovered to IDLE)
//   SER_GAP_W   : width of the inter-word gap counter
package ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } ser_state_t;

    localparam int SER_GAP_W = 4;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the serial pattern detector.
// Accepts WIDTH-bit words over valid/ready and emits them one bit per clock,
// framed by ser_valid/ser_last. ser_bit is held low whenever no payload bit
// is on the line, so the detector sees a clean 0 between words.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    word to serialize, sampled on the accepting edge only
//   in_valid   upstream holds a word
//   in_ready   block accepts a word this cycle (state/counter decode only)
//   ser_bit    current serial bit, 0 when ser_valid=0
//   ser_valid  ser_bit is a payload bit
//   ser_last   final bit of a word
//   busy       FSM not in IDLE
//   state_dbg  FSM state for waveform debug
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a word, in_ready high
// SHIFT   | driving payload bits; reloads gaplessly at count 0 when GAP=0
// GAP     | forced idle cycles between words, line held low
// 2'b11   | unused, returns to IDLE on the next edge
module bit_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [SER_GAP_W-1:0] GAP_LOAD = SER_GAP_W'((GAP > 0) ? GAP - 1 : 0);

    ser_state_t           state, state_nxt;
    logic [WIDTH-1:0]     shreg, shreg_nxt;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic [SER_GAP_W-1:0] gap_cnt, gap_cnt_nxt;

    logic                 out_bit;
    logic [WIDTH-1:0]     shreg_shifted;

    // The output end of the register depends on bit order; shifting always
    // moves toward that end and fills with zeros.
    assign out_bit       = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
    assign shreg_shifted = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                            : {1'b0, shreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        gap_cnt_nxt = gap_cnt;
        in_ready    = 1'b0;
        ser_valid   = 1'b0;
        ser_bit     = 1'b0;
        ser_last    = 1'b0;

        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shreg_nxt   = in_data;
                    bit_cnt_nxt = CNT_LOAD;
                    state_nxt   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                ser_valid = 1'b1;
                ser_bit   = out_bit;
                shreg_nxt = shreg_shifted;
                if (bit_cnt != '0) begin
                    bit_cnt_nxt = bit_cnt - 1'b1;
                end else begin
                    ser_last = 1'b1;
                    if (GAP > 0) begin
                        gap_cnt_nxt = GAP_LOAD;
                        state_nxt   = ST_GAP;
                    end else begin
                        // Last bit doubles as the next accept window.
                        in_ready = 1'b1;
                        if (in_valid) begin
                            shreg_nxt   = in_data;
                            bit_cnt_nxt = CNT_LOAD;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
            end

            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer. Three instances share clk/rst:
//   u0: WIDTH=8, MSB-first, GAP=0   u1: GAP=2   u2: LSB-first
// A scoreboard per instance gets the expected bit stream of each accepted
// word and is drained as ser_valid bits appear. Scripted checks cover
// handshake timing, framing and state sequencing.
module tb_bit_serializer;

    localparam int W = 8;

    typedef struct {
        logic b;
        logic l;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data   [3];
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         ser_bit   [3];
    logic         ser_valid [3];
    logic         ser_last  [3];
    logic         busy      [3];
    logic [1:0]   state_dbg [3];

    int   tests  = 0;
    int   fails  = 0;
    bit   armed  = 1'b0;
    exp_t sb[3][$];
    bit   msb_cfg[3] = '{1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1), .GAP(0)) u0 (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .ser_bit(ser_bit[0]), .ser_valid(ser_valid[0]),
        .ser_last(ser_last[0]), .busy(busy[0]), .state_dbg(state_dbg[0]));

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1), .GAP(2)) u1 (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .ser_bit(ser_bit[1]), .ser_valid(ser_valid[1]),
        .ser_last(ser_last[1]), .busy(busy[1]), .state_dbg(state_dbg[1]));

    bit_serializer #(.WIDTH(W), .MSB_FIRST(0), .GAP(0)) u2 (
        .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .ser_bit(ser_bit[2]), .ser_valid(ser_valid[2]),
        .ser_last(ser_last[2]), .busy(busy[2]), .state_dbg(state_dbg[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare the bit on the line, then record any accept that
    // the coming edge will take. A reset edge discards queued bits.
    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 3; k++) begin
                if (ser_valid[k] === 1'b1) begin
                    if (sb[k].size() == 0) begin
                        check($sformatf("u%0d_unexpected_bit", k), 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb[k].pop_front();
                        check($sformatf("u%0d_ser_bit", k), 32'(ser_bit[k]), 32'(e.b));
                        check($sformatf("u%0d_ser_last", k), 32'(ser_last[k]), 32'(e.l));
                    end
                end else begin
                    check($sformatf("u%0d_idle_bit", k), 32'(ser_bit[k]), 32'd0);
                    check($sformatf("u%0d_idle_last", k), 32'(ser_last[k]), 32'd0);
                end
                if (rst) begin
                    sb[k].delete();
                end else if (in_valid[k] && in_ready[k]) begin
                    for (int i = 0; i < W; i++) begin
                        exp_t e;
                        e.b = msb_cfg[k] ? in_data[k][W-1-i] : in_data[k][i];
                        e.l = (i == W - 1);
                        sb[k].push_back(e);
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_data[k]  = '0;
            in_valid[k] = 1'b0;
        end

        // Reset held 3 cycles with in_valid high: nothing may be accepted.
        rst         = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0]  = 8'hB4;
        for (int c = 0; c < 3; c++) begin
            tick();
            armed = 1'b1;
            check("rst_ser_valid", 32'(ser_valid[0]), 32'd0);
            check("rst_ser_bit", 32'(ser_bit[0]), 32'd0);
            check("rst_ser_last", 32'(ser_last[0]), 32'd0);
            check("rst_busy", 32'(busy[0]), 32'd0);
            check("rst_state_dbg", 32'(state_dbg[0]), 32'd0);
        end
        rst         = 1'b0;
        in_valid[0] = 1'b0;
        check("post_rst_in_ready", 32'(in_ready[0]), 32'd1);
        tick();
        check("post_rst_no_accept", 32'(busy[0]), 32'd0);

        // Single word 8'hB4, MSB first.
        in_data[0]  = 8'hB4;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        in_data[0]  = 8'h5A;
        for (int c = 1; c <= W; c++) begin
            check("single_valid", 32'(ser_valid[0]), 32'd1);
            check("single_last", 32'(ser_last[0]), 32'(c == W));
            if (c < W) check("single_ready_low", 32'(in_ready[0]), 32'd0);
            tick();
        end
        check("single_back_idle", 32'(state_dbg[0]), 32'd0);
        check("single_not_busy", 32'(busy[0]), 32'd0);

        // Back-to-back 8'hFF then 8'h00, in_valid held.
        in_data[0]  = 8'hFF;
        in_valid[0] = 1'b1;
        tick();
        in_data[0] = 8'h00;
        for (int c = 1; c <= 2 * W; c++) begin
            check("b2b_contiguous", 32'(ser_valid[0]), 32'd1);
            check("b2b_bit", 32'(ser_bit[0]), 32'(c <= W));
            if (c == W) check("b2b_ready_on_last", 32'(in_ready[0]), 32'd1);
            tick();
            if (c == W) in_valid[0] = 1'b0;
        end
        check("b2b_done", 32'(ser_valid[0]), 32'd0);
        check("b2b_idle", 32'(busy[0]), 32'd0);

        // GAP=2: two words of 8'hC3, next accept WIDTH+GAP+1 cycles later.
        in_data[1]  = 8'hC3;
        in_valid[1] = 1'b1;
        tick();
        for (int c = 1; c <= W; c++) begin
            check("gap_shift_state", 32'(state_dbg[1]), 32'd1);
            check("gap_ready_low", 32'(in_ready[1]), 32'd0);
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            check("gap_state", 32'(state_dbg[1]), 32'd2);
            check("gap_valid_low", 32'(ser_valid[1]), 32'd0);
            check("gap_bit_low", 32'(ser_bit[1]), 32'd0);
            check("gap_ready_low2", 32'(in_ready[1]), 32'd0);
            tick();
        end
        check("gap_idle_state", 32'(state_dbg[1]), 32'd0);
        check("gap_idle_ready", 32'(in_ready[1]), 32'd1);
        tick();
        in_valid[1] = 1'b0;
        check("gap_second_start", 32'(ser_valid[1]), 32'd1);
        check("gap_second_bit", 32'(ser_bit[1]), 32'd1);
        for (int c = 0; c < W + 3; c++) tick();
        check("gap_final_idle", 32'(busy[1]), 32'd0);

        // LSB first, 8'h01.
        in_data[2]  = 8'h01;
        in_valid[2] = 1'b1;
        tick();
        in_valid[2] = 1'b0;
        check("lsb_first_bit", 32'(ser_bit[2]), 32'd1);
        tick();
        check("lsb_second_bit", 32'(ser_bit[2]), 32'd0);
        for (int c = 0; c < W; c++) tick();
        check("lsb_idle", 32'(busy[2]), 32'd0);

        // Reset after the 3rd bit of 8'hFF: word discarded, no ser_last.
        in_data[0]  = 8'hFF;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        tick();
        check("midrst_third_bit", 32'(ser_bit[0]), 32'd1);
        rst = 1'b1;
        tick();
        check("midrst_valid", 32'(ser_valid[0]), 32'd0);
        check("midrst_bit", 32'(ser_bit[0]), 32'd0);
        check("midrst_last", 32'(ser_last[0]), 32'd0);
        rst = 1'b0;
        check("midrst_ready", 32'(in_ready[0]), 32'd1);
        for (int c = 0; c < W; c++) begin
            check("midrst_no_tail", 32'(ser_valid[0]), 32'd0);
            tick();
        end

        for (int k = 0; k < 3; k++) begin
            check($sformatf("u%0d_sb_drained", k), 32'(sb[k].size()), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
